// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared state/mode encodings and default phase timing for the RTC bus sequencer
package rtc_bus_pkg;
    typedef enum logic [3:0] {
        IDLE, W_WAIT, A_REQ, A_SU, A_PW, A_H, D_REQ, D_SU, D_PW, D_H, ADV
    } state_t;
    typedef enum logic {M_WRITE, M_READ} mode_t;
    localparam int T_SU_DEF = 2;
    localparam int T_PW_DEF = 4;
    localparam int T_H_DEF  = 2;
    localparam int T_TO_DEF = 255;
endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: loadable 8-bit down-counter; done while the count sits at zero
module rtc_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);
    logic [7:0] cnt;
    always_ff @(posedge clk)
        if (!reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != 8'd0) cnt <= cnt - 8'd1;
    assign done = cnt == 8'd0;
endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: drives multiplexed RTC bus cycles for the write machine and single-byte reads
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int T_SU = T_SU_DEF,
    parameter int T_PW = T_PW_DEF,
    parameter int T_H  = T_H_DEF,
    parameter int T_TO = T_TO_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic       wr_done,
    input  logic [7:0] wr_byte,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    input  logic [7:0] ad_in,
    output logic       dir_ph,
    output logic       dat_ph,
    output logic       cambio_estado,
    output logic       rtc_cs_n,
    output logic       rtc_rd_n,
    output logic       rtc_wr_n,
    output logic       rtc_ad,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       to_err
);
    state_t     state, state_nx;
    mode_t      mode;
    logic       rd_pend, t_load, t_done, is_w, a_ph, d_ph;
    logic [7:0] t_val;

    rtc_phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = wr_req ? A_REQ : rd_pend ? A_SU : IDLE;
            W_WAIT:  state_nx = wr_req ? A_REQ : (wr_done || t_done) ? IDLE : W_WAIT;
            A_REQ:   state_nx = A_SU;
            A_SU:    state_nx = t_done ? A_PW : A_SU;
            A_PW:    state_nx = t_done ? A_H : A_PW;
            A_H:     state_nx = t_done ? (is_w ? D_REQ : D_SU) : A_H;
            D_REQ:   state_nx = D_SU;
            D_SU:    state_nx = t_done ? D_PW : D_SU;
            D_PW:    state_nx = t_done ? D_H : D_PW;
            D_H:     state_nx = t_done ? ADV : D_H;
            ADV:     state_nx = (!is_w || wr_done) ? IDLE : W_WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // every state change reloads the timer with the length of the state being entered
    always_comb begin
        t_load = state_nx != state;
        t_val  = (state_nx == A_SU || state_nx == D_SU) ? 8'(T_SU - 1) :
                 (state_nx == A_PW || state_nx == D_PW) ? 8'(T_PW - 1) :
                 (state_nx == A_H  || state_nx == D_H)  ? 8'(T_H - 1)  :
                 (state_nx == W_WAIT)                   ? 8'(T_TO - 1) : 8'd0;
    end

    always_ff @(posedge clk)
        if (!reset) begin
            state   <= IDLE;
            mode    <= M_WRITE;
            rd_pend <= 1'b0;
            rd_data <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx != IDLE) mode <= wr_req ? M_WRITE : M_READ;
            if (state == IDLE && !wr_req && rd_pend) rd_pend <= 1'b0;
            else if (rd_req) rd_pend <= 1'b1;
            if (state == D_PW && t_done && !is_w) rd_data <= ad_in;
        end

    always_comb begin
        is_w          = mode == M_WRITE;
        a_ph          = state inside {A_SU, A_PW, A_H};
        d_ph          = state inside {D_SU, D_PW, D_H};
        rtc_cs_n      = !(a_ph || d_ph || state == D_REQ);
        rtc_ad        = d_ph || state == D_REQ;
        rtc_wr_n      = !(state == A_PW || (state == D_PW && is_w));
        rtc_rd_n      = !(state == D_PW && !is_w);
        ad_oe         = a_ph || (d_ph && is_w);
        ad_out        = !ad_oe ? 8'd0 : is_w ? wr_byte : rd_addr;
        dir_ph        = state == A_REQ;
        dat_ph        = state == D_REQ;
        cambio_estado = state == ADV && is_w;
        rd_valid      = state == ADV && !is_w;
        busy          = state != IDLE;
        to_err        = state == W_WAIT && !wr_req && !wr_done && t_done;
    end
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: directed stimulus with a queued scoreboard checked by a negedge monitor
module tb_rtc_bus_sequencer;
    logic       clk = 1'b0, reset = 1'b0;
    logic       wr_req = 1'b0, wr_done = 1'b0, rd_req = 1'b0;
    logic [7:0] wr_byte = '0, rd_addr = '0, ad_in = '0;
    logic       dir_ph, dat_ph, cambio_estado, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad;
    logic [7:0] ad_out, rd_data;
    logic       ad_oe, rd_valid, busy, to_err;

    rtc_bus_sequencer dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .wr_done(wr_done), .wr_byte(wr_byte),
        .rd_req(rd_req), .rd_addr(rd_addr), .ad_in(ad_in), .dir_ph(dir_ph), .dat_ph(dat_ph),
        .cambio_estado(cambio_estado), .rtc_cs_n(rtc_cs_n), .rtc_rd_n(rtc_rd_n),
        .rtc_wr_n(rtc_wr_n), .rtc_ad(rtc_ad), .ad_out(ad_out), .ad_oe(ad_oe),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .to_err(to_err)
    );

    always #5 clk = ~clk;

    localparam int K_DIR = 0, K_DAT = 1, K_CAM = 2, K_WR = 3, K_RD = 4, K_RDV = 5, K_TO = 6;
    typedef struct {
        int          kind;
        int          cyc;
        logic [15:0] data;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0, checks = 0, failures = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int k, input int c, input logic [15:0] d);
        exp_q.push_back('{k, c, d});
    endtask

    task automatic emit(input int k, input int c, input logic [15:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event unexpected: got kind=%0d cyc=%0d data=%h, expected none", k, c, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != c || e.data != d) begin
                failures++;
                $display("FAIL event: got kind=%0d cyc=%0d data=%h, expected kind=%0d cyc=%0d data=%h",
                         k, c, d, e.kind, e.cyc, e.data);
            end
        end
    endtask

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // monitor: strobe-low runs are reported when they end, with start cycle, length and bus byte
    initial begin
        int wr_len = 0, wr_st = 0, rd_len = 0, rd_st = 0;
        logic [7:0] wr_dat = '0;
        logic rd_oe = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!rtc_wr_n) begin
                    if (wr_len == 0) begin wr_st = cyc; wr_dat = ad_out; end
                    else if (ad_out != wr_dat) wr_dat = 8'hEE;
                    wr_len++;
                end else if (wr_len != 0) begin
                    emit(K_WR, wr_st, {8'(wr_len), wr_dat});
                    wr_len = 0;
                end
                if (!rtc_rd_n) begin
                    if (rd_len == 0) begin rd_st = cyc; rd_oe = 1'b0; end
                    rd_oe = rd_oe | ad_oe;
                    rd_len++;
                end else if (rd_len != 0) begin
                    emit(K_RD, rd_st, {8'(rd_len), 7'd0, rd_oe});
                    rd_len = 0;
                end
                if (dir_ph) emit(K_DIR, cyc, 16'd0);
                if (dat_ph) emit(K_DAT, cyc, 16'd0);
                if (cambio_estado) emit(K_CAM, cyc, 16'd0);
                if (rd_valid) emit(K_RDV, cyc, {8'd0, rd_data});
                if (to_err) emit(K_TO, cyc, {13'd0, rtc_cs_n, rtc_wr_n, rtc_rd_n});
            end
        end
    end

    function automatic logic sig(input int s);
        return s == 0 ? dir_ph : s == 1 ? dat_ph : s == 2 ? cambio_estado : s == 3 ? rd_valid : !busy;
    endfunction

    task automatic wait_for(input int s, input string nm);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!sig(s) && n < 500);
        if (!sig(s)) begin
            checks++;
            failures++;
            $display("FAIL wait %s: not seen within 500 cycles, expected asserted", nm);
        end
    endtask

    task automatic push_read(input int s, input logic [7:0] a, input logic [7:0] d);
        push(K_WR, s + 2, {8'd4, a});
        push(K_RD, s + 10, 16'h0400);
        push(K_RDV, s + 16, {8'd0, d});
    endtask

    // one write byte: address on dir_ph, data on dat_ph, wr_done answered on cambio_estado
    task automatic write_byte(input logic [7:0] a, input logic [7:0] d, input logic last,
                              input logic rdp, output int b);
        wr_req = 1'b1;
        wr_byte = a;
        b = cyc + 1;
        push(K_DIR, b, 16'd0);
        push(K_WR, b + 3, {8'd4, a});
        push(K_DAT, b + 9, 16'd0);
        push(K_WR, b + 12, {8'd4, d});
        push(K_CAM, b + 18, 16'd0);
        wait_for(0, "dir_ph");
        wr_req = 1'b0; rd_req = rdp;
        @(posedge clk); #1; rd_req = 1'b0;
        wait_for(1, "dat_ph");
        wr_byte = d; rd_req = rdp;
        @(posedge clk); #1; rd_req = 1'b0;
        wait_for(2, "cambio_estado");
        wr_done = last; rd_req = rdp;
        @(posedge clk); #1; wr_done = 1'b0; rd_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, b2, c;
        repeat (3) @(posedge clk);
        #1;
        check("reset_strobes", {5'd0, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad, ad_oe, busy,
              dir_ph, dat_ph, cambio_estado, rd_valid, to_err}, 16'h0700);
        check("reset_ad_out", {8'd0, ad_out}, 16'h0000);
        check("reset_rd_data", {8'd0, rd_data}, 16'h0000);
        reset = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        write_byte(8'h24, 8'h15, 1'b1, 1'b0, b);
        check("single_byte_idle", {15'd0, busy}, 16'd0);

        rd_addr = 8'h21; ad_in = 8'h59; rd_req = 1'b1;
        c = cyc;
        push_read(c + 2, 8'h21, 8'h59);
        @(posedge clk); #1; rd_req = 1'b0;
        wait_for(3, "rd_valid");
        check("read_rd_data", {8'd0, rd_data}, 16'h0059);
        wait_for(4, "idle_after_read");

        ad_in = 8'hA7; rd_addr = 8'h2C; rd_req = 1'b1;
        write_byte(8'h10, 8'h20, 1'b1, 1'b0, b);
        push_read(b + 20, 8'h2C, 8'hA7);
        wait_for(3, "rd_valid_after_write");
        wait_for(4, "idle_after_both");

        ad_in = 8'h3C; rd_addr = 8'h0E;
        write_byte(8'h30, 8'h01, 1'b0, 1'b1, b);
        check("session_open_w_wait", {15'd0, busy}, 16'd1);
        write_byte(8'h31, 8'h02, 1'b1, 1'b0, b2);
        push_read(b2 + 20, 8'h0E, 8'h3C);
        wait_for(3, "rd_valid_after_session");
        wait_for(4, "idle_after_session");

        write_byte(8'h40, 8'h41, 1'b0, 1'b0, b);
        push(K_TO, b + 273, 16'h0007);
        wait_for(4, "idle_after_timeout");
        check("timeout_idle_strobes", {11'd0, busy, rtc_cs_n, rtc_wr_n, rtc_rd_n, ad_oe}, 16'h000E);

        write_byte(8'h50, 8'h51, 1'b0, 1'b0, b);
        wr_done = 1'b1;
        @(posedge clk); #1; wr_done = 1'b0;
        check("w_wait_done_idle", {15'd0, busy}, 16'd0);

        wr_req = 1'b1; wr_byte = 8'h33;
        b = cyc + 1;
        push(K_DIR, b, 16'd0);
        push(K_WR, b + 3, 16'h0233);
        @(posedge clk); #1; wr_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_in_a_pw", {15'd0, rtc_wr_n}, 16'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_reset_strobes", {13'd0, rtc_wr_n, rtc_cs_n, busy}, 16'h0006);
        check("mid_reset_rd_data", {8'd0, rd_data}, 16'h0000);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
